// File: rtl/wb_store_queue_if.sv
// Bundle of the writeback-to-store-queue, store-queue-to-dcache and load-check signals.
// Purely structural; no logic or latency of its own.
// The master side drives requests and dc_req_ready; the slave side owns the queue status.
interface wb_store_queue_if;
  logic        mem_ld;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [1:0]  memsize;
  logic [6:0]  inst_ptcid;
  logic        wbaq_full;
  logic        wbaq_empty;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [63:0] dc_req_data;
  logic [1:0]  dc_req_size;
  logic [6:0]  dc_req_ptcid;
  logic        dc_req_ready;
  logic [31:0] ld_chk_addr;
  logic [1:0]  ld_chk_size;
  logic        ld_conflict;
  logic        ovf_err;

  modport master (
    output mem_ld, mem_addr, mem_data, memsize, inst_ptcid, dc_req_ready,
           ld_chk_addr, ld_chk_size,
    input  wbaq_full, wbaq_empty, dc_req_valid, dc_req_addr, dc_req_data,
           dc_req_size, dc_req_ptcid, ld_conflict, ovf_err
  );

  modport slave (
    input  mem_ld, mem_addr, mem_data, memsize, inst_ptcid, dc_req_ready,
           ld_chk_addr, ld_chk_size,
    output wbaq_full, wbaq_empty, dc_req_valid, dc_req_addr, dc_req_data,
           dc_req_size, dc_req_ptcid, ld_conflict, ovf_err
  );
endinterface

// File: rtl/wb_store_queue.sv
// In-order write-back store queue draining committed stores to the dcache write port.
// Latency: an entry accepted at edge N is presented at the head from cycle N+1 (no bypass).
// Backpressure: wbaq_full (registered) stalls writeback; head holds until dc_req_ready.
// Optional load/store granule overlap check enabled by `define WBAQ_LD_CONFLICT_EN.
module wb_store_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  wb_store_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0] addr_mem [DEPTH];
  logic [63:0] data_mem [DEPTH];
  logic [1:0]  size_mem [DEPTH];
  logic [6:0]  tag_mem  [DEPTH];

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   count;
  logic             enq;
  logic             deq;

  // Status decodes only from registered count, so no path from mem_ld/dc_req_ready.
  assign bus.wbaq_full    = (count == FULL_CNT);
  assign bus.wbaq_empty   = (count == '0);
  assign bus.dc_req_valid = ~bus.wbaq_empty;

  // A request arriving while full is dropped; a head is only popped when presented.
  assign enq = bus.mem_ld & ~bus.wbaq_full;
  assign deq = bus.dc_req_valid & bus.dc_req_ready;

  assign bus.dc_req_addr  = addr_mem[rp];
  assign bus.dc_req_data  = data_mem[rp];
  assign bus.dc_req_size  = size_mem[rp];
  assign bus.dc_req_ptcid = tag_mem[rp];

  // Pointers and occupancy; the drain state (idle/busy) is simply count != 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a store was offered while there was no room for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.ovf_err <= 1'b0;
    else if (bus.mem_ld & bus.wbaq_full) bus.ovf_err <= 1'b1;
  end

  // Entry payload storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wp] <= bus.mem_addr;
      data_mem[wp] <= bus.mem_data;
      size_mem[wp] <= bus.memsize;
      tag_mem[wp]  <= bus.inst_ptcid;
    end
  end

`ifdef WBAQ_LD_CONFLICT_EN
  // Each access touches at most two 8-byte granules: those of its first and last byte.
  logic [28:0]      ld_lo;
  logic [28:0]      ld_hi;
  logic [2:0]       unused_ld_lsb;
  logic [DEPTH-1:0] hit;

  assign ld_lo = bus.ld_chk_addr[31:3];
  assign {ld_hi, unused_ld_lsb} = bus.ld_chk_addr + ((32'd1 << bus.ld_chk_size) - 32'd1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_chk
    logic [PTR_W-1:0] off;
    logic             live;
    logic [28:0]      st_lo;
    logic [28:0]      st_hi;
    logic [2:0]       unused_st_lsb;

    // Slot i holds a buffered store if it sits within count slots of the head.
    assign off   = PTR_W'(i) - rp;
    assign live  = ({1'b0, off} < count);
    assign st_lo = addr_mem[i][31:3];
    assign {st_hi, unused_st_lsb} = addr_mem[i] + ((32'd1 << size_mem[i]) - 32'd1);
    assign hit[i] = live & ((ld_lo == st_lo) | (ld_lo == st_hi) |
                            (ld_hi == st_lo) | (ld_hi == st_hi));
  end

  assign bus.ld_conflict = |hit;
`else
  logic unused_ld_chk;
  assign unused_ld_chk   = ^{bus.ld_chk_addr, bus.ld_chk_size};
  assign bus.ld_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_wb_store_queue.sv
`timescale 1ns/1ps
// Directed plus random stimulus against a queue-based reference model of the store queue.
module tb_wb_store_queue;
  localparam int DEPTH = 8;
`ifdef WBAQ_LD_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [6:0]  tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_store_queue_if bus();
  wb_store_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  ent_t        q[$];
  logic        m_ovf = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] lc_addr = 32'h0;
  logic [1:0]  lc_size = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-level overlap: any load byte in the same 8-byte granule as any buffered store byte.
  function automatic logic model_conflict(input logic [31:0] la, input logic [1:0] ls);
    logic r;
    r = 1'b0;
    foreach (q[k]) begin
      for (int sb = 0; sb < (1 << q[k].size); sb++) begin
        for (int lb = 0; lb < (1 << ls); lb++) begin
          logic [31:0] sa;
          logic [31:0] lba;
          sa  = q[k].addr + 32'(sb);
          lba = la + 32'(lb);
          if (sa[31:3] == lba[31:3]) r = 1'b1;
        end
      end
    end
    return r & CONF_EN;
  endfunction

  task automatic observe();
    check("wbaq_empty", 64'(bus.wbaq_empty), 64'(q.size() == 0));
    check("wbaq_full", 64'(bus.wbaq_full), 64'(q.size() == DEPTH));
    check("dc_req_valid", 64'(bus.dc_req_valid), 64'(q.size() != 0));
    check("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
    check("ld_conflict", 64'(bus.ld_conflict), 64'(model_conflict(bus.ld_chk_addr, bus.ld_chk_size)));
    if (q.size() > 0) begin
      check("dc_req_addr", 64'(bus.dc_req_addr), 64'(q[0].addr));
      check("dc_req_data", bus.dc_req_data, q[0].data);
      check("dc_req_size", 64'(bus.dc_req_size), 64'(q[0].size));
      check("dc_req_ptcid", 64'(bus.dc_req_ptcid), 64'(q[0].tag));
    end
  endtask

  // One clock: drive at the falling edge, check, then apply the model's rules at the rising edge.
  task automatic cycle(input logic ld, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic [6:0] t, input logic rdy);
    bit   do_enq;
    bit   do_deq;
    ent_t e;
    @(negedge clk);
    bus.mem_ld       = ld;
    bus.mem_addr     = a;
    bus.mem_data     = d;
    bus.memsize      = s;
    bus.inst_ptcid   = t;
    bus.dc_req_ready = rdy;
    bus.ld_chk_addr  = lc_addr;
    bus.ld_chk_size  = lc_size;
    #1;
    observe();
    do_enq = ld && (q.size() < DEPTH);
    do_deq = (q.size() > 0) && rdy;
    if (ld && (q.size() == DEPTH)) m_ovf = 1'b1;
    e.addr = a;
    e.data = d;
    e.size = s;
    e.tag  = t;
    @(posedge clk);
    if (do_deq) void'(q.pop_front());
    if (do_enq) q.push_back(e);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b1);
  endtask

  initial begin
    bus.mem_ld       = 1'b0;
    bus.mem_addr     = 32'h0;
    bus.mem_data     = 64'h0;
    bus.memsize      = 2'b00;
    bus.inst_ptcid   = 7'h0;
    bus.dc_req_ready = 1'b0;
    bus.ld_chk_addr  = 32'h0;
    bus.ld_chk_size  = 2'b00;

    // Reset state.
    #2;
    observe();
    @(negedge clk);
    rst = 1'b1;

    // Single store: visible the cycle after acceptance, pops after one ready edge.
    cycle(1'b1, 32'h1000, 64'h1122334455667788, 2'b11, 7'h11, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);

    // Fill, then a ninth request is dropped and flags overflow.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h100 + 32'(i * 8), {32'hA5A5_0000, 32'(i)}, 2'(i), 7'(i + 1), 1'b0);
    cycle(1'b1, 32'hDEAD_BEE0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 7'h7F, 1'b0);
    // Full with a simultaneous dequeue: enqueue still blocked, full drops next cycle.
    cycle(1'b1, 32'hBAD0_0000, 64'h1, 2'b00, 7'h70, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    drain();

    // Back-to-back enqueue+dequeue across the pointer wrap at steady occupancy one.
    cycle(1'b1, 32'h4000, 64'h4000, 2'b10, 7'h40, 1'b0);
    for (int i = 1; i <= 20; i++)
      cycle(1'b1, 32'h4000 + 32'(i * 16), {32'(i), 32'h4000 + 32'(i)}, 2'(i), 7'(8'h40 + 8'(i)), 1'b1);
    drain();

    // Granule overlap: store at 0x2006 of 4 bytes touches granules 0x400 and 0x401.
    lc_addr = 32'h2008;
    lc_size = 2'b00;
    cycle(1'b1, 32'h2006, 64'hCAFE, 2'b10, 7'h22, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    lc_addr = 32'h2010;
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    lc_addr = 32'h2000;
    lc_size = 2'b11;
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    // Store spanning the top of the address space wraps into granule 0.
    lc_addr = 32'h0000_0004;
    lc_size = 2'b01;
    cycle(1'b1, 32'hFFFF_FFFC, 64'h55, 2'b11, 7'h23, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b0);
    drain();

    // Random traffic in a narrow address window so overlaps actually occur.
    for (int i = 0; i < 400; i++) begin
      lc_addr = 32'h3000 + 32'($urandom_range(0, 63));
      lc_size = 2'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 1)), 32'h3000 + 32'($urandom_range(0, 63)),
            {$urandom, $urandom}, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
            ($urandom_range(0, 9) < 4));
    end
    drain();

    // Reset while draining three entries: everything returns to reset values at once.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h5000 + 32'(i * 8), 64'(i), 2'b11, 7'(i), 1'b0);
    cycle(1'b1, 32'h5100, 64'h0, 2'b00, 7'h0, 1'b0);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b1);
    bus.mem_ld = 1'b0;
    #2;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    observe();
    @(negedge clk);
    rst = 1'b1;

    // Normal operation after reset.
    cycle(1'b1, 32'h6000, 64'h6000, 2'b01, 7'h60, 1'b0);
    cycle(1'b1, 32'h6008, 64'h6008, 2'b10, 7'h61, 1'b1);
    cycle(1'b0, 32'h0, 64'h0, 2'b00, 7'h0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
